telemetre_echo_meter: RTL

- Downstream companion of the trigger divider in the ultrasonic telemeter chain.
- Watches the divider's trigger output and the sensor's asynchronous echo line.
- Measures the echo high-time and converts it to distance in centimetres (truncated).
- Presents one result per trigger with a single-cycle valid strobe, or a timeout flag when no usable echo arrives.

---
 rtl/telemetre_echo_meter_if.sv | 15 +
 rtl/telemetre_echo_meter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/telemetre_echo_meter_if.sv
// Signal bundle between the trigger divider / echo sensor and the echo meter.
// slave = meter side, master = stimulus/consumer side.
interface telemetre_echo_meter_if #(
  parameter int DIST_W = 16
);
  logic              trig;
  logic              echo;
  logic [DIST_W-1:0] distance;
  logic              valid;
  logic              timeout;
  logic              busy;

  modport slave  (input trig, echo, output distance, valid, timeout, busy);
  modport master (output trig, echo, input distance, valid, timeout, busy);
endinterface

// File: rtl/telemetre_echo_meter.sv
// Ultrasonic echo meter: times the echo high pulse after each trigger and
// reports distance in cm, or a timeout result when no usable echo arrives.
module telemetre_echo_meter #(
  parameter int US_DIV     = 50,
  parameter int CM_DIV     = 58,
  parameter int TIMEOUT_US = 30000,
  parameter int MAX_CM     = 500,
  parameter int DIST_W     = 16,
  parameter bit TRIG_POL   = 1'b1
) (
  input  logic                   clkIn,
  input  logic                   rst_n,
  telemetre_echo_meter_if.slave  bus
);

  localparam int PRE_W = $clog2(US_DIV + 1);
  localparam int US_W  = $clog2(TIMEOUT_US + 1);
  localparam int SUB_W = $clog2(CM_DIV + 1);

  localparam logic [PRE_W-1:0]  PRE_TC = PRE_W'(US_DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_TC = SUB_W'(CM_DIV - 1);
  localparam logic [US_W-1:0]   US_TC  = US_W'(TIMEOUT_US - 1);
  localparam logic [DIST_W-1:0] CM_MAX = DIST_W'(MAX_CM);

  typedef enum logic [1:0] {IDLE, WAIT_ECHO, MEASURE, RECOVER} state_e;

  state_e             state_q, state_d;
  logic               echo_m_q, echo_m_d;
  logic               echo_s_q, echo_s_d;
  logic               trig_dly_q, trig_dly_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [US_W-1:0]    us_q, us_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DIST_W-1:0]  cm_q, cm_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               tmo_q, tmo_d;
  logic               valid_q, valid_d;

  logic               counting;
  logic               us_tick;
  logic               us_expire;
  logic               trig_end;

  always_comb begin
    state_d    = state_q;
    echo_m_d   = bus.echo;
    echo_s_d   = echo_m_q;
    trig_dly_d = bus.trig;
    pre_d      = pre_q;
    us_d       = us_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    dist_d     = dist_q;
    tmo_d      = tmo_q;
    valid_d    = 1'b0;

    trig_end  = (trig_dly_q == TRIG_POL) && (bus.trig != TRIG_POL);
    counting  = (state_q == WAIT_ECHO) || (state_q == MEASURE);
    us_tick   = counting && (pre_q == PRE_TC);
    us_expire = us_tick && (us_q == US_TC);

    if (counting) pre_d = us_tick ? '0 : pre_q + 1'b1;
    if (us_tick)  us_d  = us_q + 1'b1;

    // cm_d includes the tick of the current cycle so the exit cycle still counts.
    if (state_q == MEASURE && us_tick) begin
      if (sub_q == SUB_TC) begin
        sub_d = '0;
        cm_d  = (cm_q >= CM_MAX) ? CM_MAX : cm_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (trig_end) begin
          state_d = WAIT_ECHO;
          us_d    = '0;
        end
      end
      WAIT_ECHO: begin
        if (echo_s_q) begin
          state_d = MEASURE;
          sub_d   = '0;
          cm_d    = '0;
        end else if (us_expire) begin
          state_d = RECOVER;
          dist_d  = CM_MAX;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      MEASURE: begin
        if (us_expire) begin
          state_d = RECOVER;
          dist_d  = CM_MAX;
          tmo_d   = 1'b1;
          valid_d = 1'b1;
        end else if (!echo_s_q) begin
          state_d = IDLE;
          dist_d  = cm_d;
          tmo_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      RECOVER: begin
        if (!echo_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) pre_d = '0;
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      echo_m_q   <= 1'b0;
      echo_s_q   <= 1'b0;
      trig_dly_q <= 1'b0;
      pre_q      <= '0;
      us_q       <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      dist_q     <= '0;
      tmo_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      echo_m_q   <= echo_m_d;
      echo_s_q   <= echo_s_d;
      trig_dly_q <= trig_dly_d;
      pre_q      <= pre_d;
      us_q       <= us_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      dist_q     <= dist_d;
      tmo_q      <= tmo_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.distance = dist_q;
  assign bus.valid    = valid_q;
  assign bus.timeout  = tmo_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
